mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory port (address, to_mem, from_mem, mem_clock, mem_write) between three requesters: instruction fetch, data LD/ST, and the program loader.
- Sequences every access as a fixed 4-cycle setup/strobe/hold transaction, so the controller no longer toggles mem_clock itself.
- Uses fixed priority with an anti-starvation guard for fetch.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, data width
STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch outranks data (1..15)

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high reset
f_req  in  1  fetch request (read only)
f_addr  in  ADDR_W  fetch address
f_ack  out  1  fetch done pulse
f_rdata  out  DATA_W  fetch read data
d_req  in  1  data request
d_we  in  1  data write enable (1=ST, 0=LD)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  data write value
d_ack  out  1  data done pulse
d_rdata  out  DATA_W  data read data
l_req  in  1  loader write request
l_addr  in  ADDR_W  loader address
l_wdata  in  DATA_W  loader write value
l_ack  out  1  loader done pulse
address  out  ADDR_W  memory address
to_mem  out  DATA_W  memory write data
from_mem  in  DATA_W  memory read data
mem_clock  out  1  memory strobe
mem_write  out  1  memory write enable
busy  out  1  transaction in progress
grant  out  2  owner: 0 none, 1 fetch, 2 data, 3 loader

Behaviour:
- Reset (async, immediate): state=IDLE; address, to_mem, mem_clock, mem_write, busy, grant, all acks, f_rdata, d_rdata=0; starvation counter=0.
- All outputs are registered.
- FSM: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. Each state lasts one cycle.
- IDLE:
  - Sample requests and pick a winner, if any.
  - Latch the winner's address, write data and write enable into address/to_mem/mem_write.
  - Set grant and busy=1, go to SETUP.
  - With no request: stay in IDLE with grant=0, busy=0.
- SETUP: mem_clock=0; address, to_mem and mem_write are stable.
- STROBE: mem_clock=1.
- Leaving STROBE (edge): for a read, capture from_mem into the owner's rdata register.
- HOLD:
  - mem_clock=0, mem_write=0.
  - Owner's ack=1 for exactly this cycle; the owner's rdata is valid and is held until that port's next read completes.
- Leaving HOLD: clear ack, grant and busy; go to IDLE.
- Throughput: 4 cycles per access. Request-to-ack latency is 4 cycles when the arbiter is idle.
- Handshake:
  - Requester holds req and its operands stable until it sees ack.
  - Requester deasserts req at the clock edge ending the ack cycle.
  - Req still high in the following IDLE is treated as a new request.
  - Operand changes while granted are ignored, because operands are latched in IDLE.
- Priority: loader > data > fetch. Exception: when the starvation counter reaches STARVE_LIMIT, fetch beats data; loader is still highest.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each IDLE arbitration where f_req=1 and fetch loses.
  - Clears when fetch is granted.
  - Clears in IDLE when f_req=0.
- Fetch grants always have mem_write=0. Loader grants always have mem_write=1.
- Simultaneous requests: all three asserted means loader is served first. Losers keep req high and compete again in the next IDLE.
- Reset mid-transaction:
  - Aborts immediately and forces mem_clock=0 and mem_write=0.
  - No ack is issued; the requester must re-issue.
  - A write aborted in STROBE may have reached memory.
- Requests are never dropped and only one ack is high at a time.

Test Plan:
- Single fetch: reset, f_req=1, f_addr=0x05, from_mem=0xA3 -> mem_clock high in cycle 3 only; f_ack high in cycle 4; f_rdata=0xA3; mem_write=0 throughout.
- Data store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x7E -> address=0x20, to_mem=0x7E, mem_write=1 through SETUP/STROBE; d_ack after 4 cycles; f_ack and l_ack stay 0.
- Three-way contention: all reqs raised in the same cycle -> grant order loader(3), data(2), fetch(1); acks at cycles 4, 8, 12.
- Starvation, STARVE_LIMIT=4: d_req held high continuously (re-asserted after each ack), f_req high -> exactly 4 data grants, then fetch granted, then the counter reads 0.
- Reset in STROBE during d_we=1 -> mem_clock and mem_write are 0 within the same cycle; no d_ack; after release, busy=0 and grant=0.
- Held request: f_req kept high after f_ack -> second fetch begins in the next IDLE; f_rdata updates only at the second completion.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch, data and loader requesters,
// running each access as a fixed IDLE/SETUP/STROBE/HOLD sequence with registered outputs.
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              l_req,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] to_mem,
  input  logic [DATA_W-1:0] from_mem,
  output logic              mem_clock,
  output logic              mem_write,
  output logic              busy,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_F    = 2'd1;
  localparam logic [1:0] G_D    = 2'd2;
  localparam logic [1:0] G_L    = 2'd3;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       starved;
  logic [1:0] win;

  assign starved = (starve_cnt == LIMIT);

  // Loader always first; a starved fetch jumps ahead of data.
  always_comb begin
    win = G_NONE;
    if (l_req)                win = G_L;
    else if (f_req && starved) win = G_F;
    else if (d_req)           win = G_D;
    else if (f_req)           win = G_F;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      address    <= '0;
      to_mem     <= '0;
      mem_clock  <= 1'b0;
      mem_write  <= 1'b0;
      busy       <= 1'b0;
      grant      <= G_NONE;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      l_ack      <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!f_req || win == G_F)  starve_cnt <= '0;
          else if (!starved)         starve_cnt <= starve_cnt + 4'd1;
          if (win != G_NONE) begin
            grant <= win;
            busy  <= 1'b1;
            state <= SETUP;
            case (win)
              G_F: begin
                address   <= f_addr;
                mem_write <= 1'b0;
              end
              G_D: begin
                address   <= d_addr;
                to_mem    <= d_wdata;
                mem_write <= d_we;
              end
              default: begin
                address   <= l_addr;
                to_mem    <= l_wdata;
                mem_write <= 1'b1;
              end
            endcase
          end
        end
        SETUP: begin
          mem_clock <= 1'b1;
          state     <= STROBE;
        end
        STROBE: begin
          // mem_write still holds the latched direction here; it drops entering HOLD.
          if (!mem_write) begin
            if (grant == G_F) f_rdata <= from_mem;
            if (grant == G_D) d_rdata <= from_mem;
          end
          mem_clock <= 1'b0;
          mem_write <= 1'b0;
          f_ack     <= (grant == G_F);
          d_ack     <= (grant == G_D);
          l_ack     <= (grant == G_L);
          state     <= HOLD;
        end
        default: begin
          f_ack <= 1'b0;
          d_ack <= 1'b0;
          l_ack <= 1'b0;
          grant <= G_NONE;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
